// File: rtl/vga_fb_arbiter_pkg.sv
// Shared widths and flush-FSM encoding for the framebuffer arbiter.
package vga_fb_arbiter_pkg;

    localparam int FB_ADDR_W = 20;
    localparam int FB_DATA_W = 12;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } fbState_t;

endpackage

// File: rtl/vga_wr_fifo.sv
// Posted-write FIFO; push/pop take effect on the edge, head is combinational from storage.
// Caller guards push with !oFull and pop with !oEmpty; pointers carry a wrap bit.
module vga_wr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iPush_Data,
    input  logic             iPop,
    output logic [WIDTH-1:0] oHead,
    output logic [AW:0]      oLevel,
    output logic             oFull,
    output logic             oEmpty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (iPush) wrPtr <= wrPtr + (AW+1)'(1);
            if (iPop)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iPush) mem[wrPtr[AW-1:0]] <= iPush_Data;
    end

    assign oHead  = mem[rdPtr[AW-1:0]];
    assign oLevel = wrPtr - rdPtr;
    assign oFull  = (oLevel == (AW+1)'(DEPTH));
    assign oEmpty = (wrPtr == rdPtr);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads always win (data 2 edges after request),
// posted writes drain from a FIFO on idle cycles; oWr_Ready drops when full or flushing.
module vga_fb_arbiter
    import vga_fb_arbiter_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 1024,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iDisp_Req,
    input  logic [ADDR_W-1:0] iDisp_Addr,
    output logic [DATA_W-1:0] oDisp_Data,
    output logic              oDisp_Valid,
    input  logic              iWr_Valid,
    input  logic [ADDR_W-1:0] iWr_Addr,
    input  logic [DATA_W-1:0] iWr_Data,
    output logic              oWr_Ready,
    output logic [LVL_W-1:0]  oWr_Level,
    input  logic              iFlush,
    output logic              oFlush_Done,
    output logic              oOverrun,
    output logic              oMem_CE,
    output logic              oMem_WE,
    output logic [ADDR_W-1:0] oMem_Addr,
    output logic [DATA_W-1:0] oMem_WData,
    input  logic [DATA_W-1:0] iMem_RData
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wrEnt_t;

    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIM);

    fbState_t         state;
    logic             rstDone;
    logic [LVL_W-1:0] level;
    logic             fifoFull;
    logic             fifoEmpty;
    wrEnt_t           head;
    wrEnt_t           pushEnt;
    logic             push;
    logic             pop;
    logic             starve;
    logic             rdPend;
    logic [CNT_W-1:0] starveCnt;

    // rstDone keeps oWr_Ready low during and for the first edge after reset.
    assign oWr_Ready = rstDone && !fifoFull && (state == ST_RUN);
    assign push      = iWr_Valid && oWr_Ready;
    assign pop       = !iDisp_Req && !fifoEmpty;
    assign pushEnt   = '{addr: iWr_Addr, data: iWr_Data};
    assign oWr_Level = level;
    assign starve    = fifoFull && iDisp_Req;

    vga_wr_fifo #(
        .WIDTH ($bits(wrEnt_t)),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iPush      (push),
        .iPush_Data (pushEnt),
        .iPop       (pop),
        .oHead      (head),
        .oLevel     (level),
        .oFull      (fifoFull),
        .oEmpty     (fifoEmpty)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oMem_CE     <= 1'b0;
            oMem_WE     <= 1'b0;
            oMem_Addr   <= '0;
            oMem_WData  <= '0;
            rdPend      <= 1'b0;
            oDisp_Valid <= 1'b0;
            oDisp_Data  <= '0;
        end else begin
            if (iDisp_Req) begin
                oMem_CE   <= 1'b1;
                oMem_WE   <= 1'b0;
                oMem_Addr <= iDisp_Addr;
            end else if (pop) begin
                oMem_CE    <= 1'b1;
                oMem_WE    <= 1'b1;
                oMem_Addr  <= head.addr;
                oMem_WData <= head.data;
            end else begin
                oMem_CE <= 1'b0;
                oMem_WE <= 1'b0;
            end
            // Stage 1: RAM latches the read; stage 2: capture its data.
            rdPend      <= oMem_CE && !oMem_WE;
            oDisp_Valid <= rdPend;
            if (rdPend) oDisp_Data <= iMem_RData;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state       <= ST_RUN;
            rstDone     <= 1'b0;
            oFlush_Done <= 1'b0;
            oOverrun    <= 1'b0;
            starveCnt   <= '0;
        end else begin
            rstDone     <= 1'b1;
            oFlush_Done <= 1'b0;
            case (state)
                ST_RUN:   if (iFlush) state <= ST_FLUSH;
                ST_FLUSH: if (level == '0) begin
                    state       <= ST_DONE;
                    oFlush_Done <= 1'b1;
                end
                ST_DONE:  state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase

            if (starve) begin
                if (starveCnt != CNT_LIM) starveCnt <= starveCnt + CNT_W'(1);
            end else begin
                starveCnt <= '0;
            end

            if (state == ST_FLUSH && level == '0)
                oOverrun <= 1'b0;
            else if (starve && starveCnt >= CNT_LIM - CNT_W'(1))
                oOverrun <= 1'b1;
        end
    end

endmodule
